// File: rtl/tmr_scrub_ctrl.sv
// Central scrub scheduler for TMR submodules: latches voter mismatches per
// source, grants one round-robin resync request at a time, counts completions.

module tmr_scrub_lane #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             err_i,
  input  logic             done_i,
  input  logic             clear_i,
  output logic             pend_o,
  output logic             pend_d_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A fresh mismatch in the completion cycle keeps the source pending.
  always_comb begin
    pend_d = err_i | (pend_q & ~done_i);
    cnt_d  = cnt_q;
    if (clear_i)                   cnt_d = '0;
    else if (done_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o   = pend_q;
  assign pend_d_o = pend_d;
  assign cnt_o    = cnt_q;
endmodule

module tmr_scrub_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_SRC-1:0]         err_i,
  input  logic [NUM_SRC-1:0]         scrub_ack_i,
  input  logic                       clear_i,
  output logic [NUM_SRC-1:0]         scrub_req_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic                       err_o,
  output logic [NUM_SRC*CNT_W-1:0]   err_cnt_o,
  output logic [$clog2(NUM_SRC)-1:0] last_src_o
);
  localparam int unsigned PW = $clog2(NUM_SRC);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_e;

  state_e                          state_q;
  logic [PW-1:0]                   sel_q, ptr_q, last_q, pick, sel_nxt;
  logic [TW-1:0]                   timer_q;
  logic [NUM_SRC-1:0]              req_q, pend, pend_d;
  logic                            busy_q, timeout_q, err_q, sticky_q, sticky_d;
  logic [NUM_SRC-1:0][CNT_W-1:0]   cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    tmr_scrub_lane #(.CNT_W(CNT_W)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .err_i    (err_i[i]),
      .done_i   (state_q == DONE && sel_q == PW'(i)),
      .clear_i  (clear_i),
      .pend_o   (pend[i]),
      .pend_d_o (pend_d[i]),
      .cnt_o    (cnt[i])
    );
  end

  // Round-robin search starting at ptr; the lowest offset wins.
  always_comb begin
    logic [PW:0] sum;
    sum  = '0;
    pick = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_SRC)) sum = sum - (PW+1)'(NUM_SRC);
      if (pend[sum[PW-1:0]]) pick = sum[PW-1:0];
    end
  end

  assign sel_nxt  = (sel_q == PW'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;
  assign sticky_d = (sticky_q & ~clear_i) | (|err_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      last_q    <= '0;
      timer_q   <= '0;
      req_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pend) begin
            state_q <= REQ;
            sel_q   <= pick;
            req_q   <= NUM_SRC'(1) << pick;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (scrub_ack_i[sel_q]) begin
            state_q <= DONE;
            req_q   <= '0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q   <= ABORT;
            req_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE, ABORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= sel_q;
          ptr_q   <= sel_nxt;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      err_q    <= (|pend_d) | sticky_d;
    end
  end

  assign scrub_req_o = req_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;
  assign err_o       = err_q;
  assign err_cnt_o   = cnt;
  assign last_src_o  = last_q;
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed and random checks of tmr_scrub_ctrl against a transaction-level
// model of pending set, round-robin pointer, counters and sticky flag.

module tb_tmr_scrub_ctrl;
  localparam int NS = 4;
  localparam int CW = 8;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NS-1:0]   err_i = '0;
  logic [NS-1:0]   scrub_ack_i = '0;
  logic            clear_i = 1'b0;
  logic [NS-1:0]   scrub_req_o;
  logic            busy_o, timeout_o, err_o;
  logic [NS*CW-1:0] err_cnt_o;
  logic [1:0]      last_src_o;

  tmr_scrub_ctrl #(.NUM_SRC(NS), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .err_i(err_i), .scrub_ack_i(scrub_ack_i),
    .clear_i(clear_i), .scrub_req_o(scrub_req_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
    .last_src_o(last_src_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit [NS-1:0] m_pend;
  int          m_cnt [NS];
  bit          m_sticky;
  int          m_ptr, m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic m_reset();
    m_pend = '0; m_sticky = 1'b0; m_ptr = 0; m_last = 0;
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
  endtask

  function automatic int m_choose();
    for (int k = 0; k < NS; k++)
      if (m_pend[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
    return -1;
  endfunction

  function automatic logic [NS*CW-1:0] m_cnt_vec();
    logic [NS*CW-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [NS-1:0] oh(input int s);
    logic [NS-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    err_i = '0; scrub_ack_i = '0; clear_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    m_reset();
  endtask

  task automatic pulse_err(input logic [NS-1:0] v);
    err_i = v;
    step();
    err_i = '0;
    m_pend |= v;
    if (v != '0) m_sticky = 1'b1;
    chk("err_o_after_pulse", err_o, 1'b1);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (scrub_req_o == '0 && n < 8) begin
      step();
      n++;
    end
  endtask

  // Target acks after dly idle cycles; err_req is driven up to the ack edge,
  // err_done and clr at the completion edge.
  task automatic grant_ack(input logic [NS-1:0] exp, input int dly,
                           input logic [NS-1:0] err_req, input logic [NS-1:0] err_done,
                           input bit clr, output int t_grant);
    int sel;
    wait_grant();
    t_grant = cyc;
    sel = m_choose();
    chk("grant", scrub_req_o, exp);
    chk("grant_model", scrub_req_o, oh(sel));
    chk("busy_req", busy_o, 1'b1);
    for (int d = 0; d < dly; d++) begin
      scrub_ack_i = NS'($urandom) & ~exp;
      err_i = err_req;
      step();
      chk("req_stable", scrub_req_o, exp);
    end
    scrub_ack_i = exp | (NS'($urandom) & ~exp);
    err_i = err_req;
    step();
    m_pend |= err_req;
    if (err_req != '0) m_sticky = 1'b1;
    chk("req_drop_on_ack", scrub_req_o, '0);
    chk("busy_done", busy_o, 1'b1);
    scrub_ack_i = '0;
    err_i = err_done;
    clear_i = clr;
    step();
    err_i = '0;
    clear_i = 1'b0;
    if (sel >= 0) begin
      m_pend[sel] = 1'b0;
      if (!clr && m_cnt[sel] < (1 << CW) - 1) m_cnt[sel]++;
      m_last = sel;
      m_ptr = (sel + 1) % NS;
    end
    m_pend |= err_done;
    if (clr) begin
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      m_sticky = 1'b0;
    end
    if (err_done != '0) m_sticky = 1'b1;
    chk("cnt", err_cnt_o, m_cnt_vec());
    chk("last_src", last_src_o, 64'(m_last));
    chk("busy_idle", busy_o, 1'b0);
    chk("timeout_quiet", timeout_o, 1'b0);
    chk("err_o", err_o, (m_pend != '0) || m_sticky);
  endtask

  task automatic grant_timeout(input logic [NS-1:0] exp, input logic [NS-1:0] err_req);
    int n, sel;
    wait_grant();
    sel = m_choose();
    chk("tgrant", scrub_req_o, exp);
    chk("tgrant_model", scrub_req_o, oh(sel));
    n = 0;
    while (scrub_req_o === exp && n < TO + 4) begin
      chk("timeout_low", timeout_o, 1'b0);
      scrub_ack_i = NS'($urandom) & ~exp;
      err_i = err_req;
      step();
      n++;
    end
    scrub_ack_i = '0;
    err_i = '0;
    m_pend |= err_req;
    if (err_req != '0) m_sticky = 1'b1;
    chk("req_cycles", 64'(n), 64'(TO));
    chk("req_drop_on_abort", scrub_req_o, '0);
    chk("timeout_pulse", timeout_o, 1'b1);
    chk("busy_abort", busy_o, 1'b1);
    step();
    if (sel >= 0) begin
      m_last = sel;
      m_ptr = (sel + 1) % NS;
    end
    chk("timeout_single", timeout_o, 1'b0);
    chk("last_src_abort", last_src_o, 64'(m_last));
    chk("cnt_abort", err_cnt_o, m_cnt_vec());
    chk("busy_after_abort", busy_o, 1'b0);
    chk("err_o_abort", err_o, (m_pend != '0) || m_sticky);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, tprev, n, sel;
    logic [NS-1:0] er, ed;

    // Reset with errors present, then first-grant latency
    err_i = 4'b0101;
    rst_ni = 1'b0;
    m_reset();
    repeat (3) step();
    chk("rst_req", scrub_req_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_cnt", err_cnt_o, '0);
    chk("rst_last", last_src_o, '0);
    rst_ni = 1'b1;
    step();
    m_pend = 4'b0101; m_sticky = 1'b1;
    chk("lat_err_o", err_o, 1'b1);
    chk("lat_no_req_yet", scrub_req_o, '0);
    step();
    err_i = '0;
    chk("lat_req", scrub_req_o, 4'b0001);
    grant_ack(4'b0001, 3, '0, '0, 1'b0, t);
    chk("t1_cnt0", err_cnt_o[7:0], 8'd1);
    grant_ack(4'b0100, 0, '0, '0, 1'b0, t);

    // All sources pulsed once, immediate acks: 3-cycle spacing
    do_reset();
    pulse_err(4'b1111);
    tprev = -1;
    for (int i = 0; i < NS; i++) begin
      grant_ack(oh(i), 0, '0, '0, 1'b0, t);
      if (tprev >= 0) chk("spacing", 64'(t - tprev), 64'd3);
      tprev = t;
    end
    step();
    chk("t2_cnt", err_cnt_o, {4{8'd1}});
    chk("t2_busy", busy_o, 1'b0);
    chk("t2_req", scrub_req_o, '0);
    chk("t2_sticky", err_o, 1'b1);

    // Target 2 never acks
    do_reset();
    pulse_err(4'b1101);
    grant_ack(4'b0001, 0, '0, '0, 1'b0, t);
    grant_timeout(4'b0100, 4'b0001);
    chk("t3_cnt2", err_cnt_o[23:16], 8'd0);
    grant_ack(4'b1000, 0, '0, '0, 1'b0, t);
    grant_ack(4'b0001, 0, '0, '0, 1'b0, t);
    grant_ack(4'b0100, 1, '0, '0, 1'b0, t);
    chk("t3_cnt2_late", err_cnt_o[23:16], 8'd1);

    // Source 1 keeps erroring through its own completion
    do_reset();
    pulse_err(4'b1111);
    grant_ack(4'b0001, 0, '0, '0, 1'b0, t);
    grant_ack(4'b0010, 1, 4'b0011, 4'b0011, 1'b0, t);
    grant_ack(4'b0100, 0, '0, '0, 1'b0, t);
    grant_ack(4'b1000, 0, '0, '0, 1'b0, t);
    grant_ack(4'b0001, 0, '0, '0, 1'b0, t);
    grant_ack(4'b0010, 0, '0, '0, 1'b0, t);
    chk("t4_cnt1", err_cnt_o[15:8], 8'd2);

    // Counter saturation, then clear coinciding with completion
    do_reset();
    pulse_err(4'b0001);
    for (int i = 0; i < 256; i++) grant_ack(4'b0001, 0, 4'b0001, 4'b0001, 1'b0, t);
    chk("t5_sat", err_cnt_o[7:0], 8'd255);
    grant_ack(4'b0001, 1, 4'b0010, '0, 1'b1, t);
    chk("t5_clear_wins", err_cnt_o[7:0], 8'd0);
    chk("t5_err_pending", err_o, 1'b1);
    grant_ack(4'b0010, 0, '0, '0, 1'b0, t);
    chk("t5_err_cleared", err_o, 1'b0);
    chk("t5_cnt1", err_cnt_o[15:8], 8'd1);

    // Asynchronous reset in the middle of a grant
    do_reset();
    pulse_err(4'b0010);
    wait_grant();
    chk("t6_req", scrub_req_o, 4'b0010);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_drop", scrub_req_o, '0);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_err", err_o, 1'b0);
    step();
    rst_ni = 1'b1;
    m_reset();
    repeat (3) step();
    chk("t6_no_regrant", scrub_req_o, '0);
    chk("t6_err_lost", err_o, 1'b0);
    pulse_err(4'b1111);
    grant_ack(4'b0001, 0, '0, '0, 1'b0, t);

    // Random traffic against the model
    do_reset();
    for (int r = 0; r < 150; r++) begin
      if (m_pend == '0) pulse_err(NS'($urandom_range(1, (1 << NS) - 1)));
      sel = m_choose();
      er = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      ed = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      n = $urandom_range(0, 5);
      if (n == 0) grant_timeout(oh(sel), er);
      else grant_ack(oh(sel), $urandom_range(0, 3), er, ed, $urandom_range(0, 4) == 0, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
